arb2_mux16_ctrl: RTL and testbench

Two-requester round-robin arbiter and output register stage for the shared 16-bit 2:1 select datapath. Each requester offers a 16-bit word with a valid/ready handshake. The block drives the datapath select to route the granted word into a single output register, presented downstream with its own valid/ready handshake. Per-requester transfer counters are provided for debug and fairness checking.

---
 rtl/arb2_mux16_ctrl.sv | 131 +++++++++++++
 tb/tb_arb2_mux16_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/arb2_mux16_ctrl.sv
// arb2_mux16_ctrl
// Two-requester round-robin arbiter driving the select of a shared 16-bit
// 2:1 datapath, followed by a single output register with its own
// valid/ready handshake. Per-requester transfer counters are kept for debug
// and fairness checking.
//
// Handshake semantics (all three ports): a word moves on a rising edge where
// valid & ready are both high. A source holds valid and its data stable
// until that edge. valid never depends on ready. ready0/ready1 depend only on
// valid0, valid1, out_valid, out_ready and the last grant, never on data.
module arb2_mux16_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             valid0,
    input  logic [WIDTH-1:0] data0,
    output logic             ready0,
    // requester 1
    input  logic             valid1,
    input  logic [WIDTH-1:0] data1,
    output logic             ready1,
    // downstream
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    // datapath select and debug
    output logic             sel,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Output register state. The state bit is also the out_valid output,
    // so the state is directly observable on the port.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             src_q,   src_d;
    logic             last_q,  last_d;   // 1 after reset: requester 0 wins the first tie
    logic [CNT_W-1:0] cnt0_q,  cnt0_d;
    logic [CNT_W-1:0] cnt1_q,  cnt1_d;

    logic             load;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic             sel_w;
    logic [WIDTH-1:0] mux_data;

    // Arbitration: a grant is only possible when the register can take a
    // word this cycle (empty, or being drained in the same cycle). Grants
    // are forced low while reset is asserted so no ready leaks out.
    always_comb begin
        load      = (state_q == ST_EMPTY) | out_ready;
        grant0    = rst_n & load & valid0 & (~valid1 | last_q);
        grant1    = rst_n & load & valid1 & (~valid0 | ~last_q);
        grant_any = grant0 | grant1;
        // Without a grant the select parks on the last winner so it does
        // not toggle for nothing.
        sel_w     = grant_any ? grant1 : last_q;
    end

    // Shared 2:1 datapath mux steered by the select.
    always_comb begin
        mux_data = sel_w ? data1 : data0;
    end

    // Next-state for the output register, grant history and counters.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        if (grant_any) begin
            // Load (possibly a same-cycle drain and refill).
            state_d = ST_FULL;
            data_d  = mux_data;
            src_d   = grant1;
            last_d  = grant1;
            if (grant0) begin
                cnt0_d = cnt0_q + CNT_ONE;
            end
            if (grant1) begin
                cnt1_d = cnt1_q + CNT_ONE;
            end
        end else if ((state_q == ST_FULL) && out_ready) begin
            // Drained with nothing to replace it; data and source hold.
            state_d = ST_EMPTY;
        end
    end

    // State registers with asynchronous active-low reset; a reset
    // mid-transfer discards the held word entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign ready0    = grant0;
    assign ready1    = grant1;
    assign sel       = sel_w;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_arb2_mux16_ctrl.sv
// Testbench for arb2_mux16_ctrl. Inputs change 1 ns after each rising edge;
// outputs are sampled on the falling edge. Expected output words are pushed
// into a queue as stimulus is issued and a monitor pops and compares them
// whenever the downstream handshake fires.
module tb_arb2_mux16_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             valid0 = 1'b0, valid1 = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] data0 = '0, data1 = '0;
    logic             ready0, ready1, out_valid, sel, out_src;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] cnt0, cnt1;

    arb2_mux16_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid0    (valid0),
        .data0     (data0),
        .ready0    (ready0),
        .valid1    (valid1),
        .data1     (data1),
        .ready1    (ready1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .out_src   (out_src),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    // ---------------- scoreboard ----------------
    // Each entry is {source, word}.
    logic [WIDTH:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic src, input logic [WIDTH-1:0] word);
        exp_q.push_back({src, word});
    endtask

    // Monitor: a word is consumed on the next rising edge whenever
    // out_valid & out_ready are high mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {15'd0, out_src, out_data}, 32'h1FFFF);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                chk("out_word", {15'd0, out_src, out_data}, {15'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic v0, input logic [WIDTH-1:0] d0,
                        input logic v1, input logic [WIDTH-1:0] d1,
                        input logic ordy);
        @(posedge clk);
        #1;
        valid0    = v0;
        data0     = d0;
        valid1    = v1;
        data1     = d1;
        out_ready = ordy;
    endtask

    // Assert reset away from any edge, check the asynchronous effect, then
    // release it just after a rising edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        valid0 = 1'b1;
        valid1 = 1'b1;
        out_ready = 1'b1;
        #1;
        exp_q.delete();
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"},  {16'd0, out_data},  32'd0);
        chk({tag, "_cnt0"},      {24'd0, cnt0},      32'd0);
        chk({tag, "_cnt1"},      {24'd0, cnt1},      32'd0);
        chk({tag, "_readies"},   {30'd0, ready1, ready0}, 32'd0);
        valid0 = 1'b0;
        valid1 = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset state with nothing ever loaded.
        #2;
        do_reset("rst0");

        // Single requester 0.
        step(1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b1);
        push_exp(1'b0, 16'hA5A5);
        @(negedge clk);
        chk("single_ready", {30'd0, ready1, ready0}, 32'h1);
        chk("single_sel", {31'd0, sel}, 32'd0);

        // Drain to empty: output full, ready high, no requester.
        step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_src", {31'd0, out_src}, 32'd0);
        chk("single_cnt0", {24'd0, cnt0}, 32'd1);
        step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_data", {16'd0, out_data}, 32'hA5A5);
        chk("idle_sel_parked", {31'd0, sel}, 32'd0);

        // Tie after reset: requester 0 first, then alternate.
        do_reset("rst1");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
            push_exp(i[0], i[0] ? 16'h2222 : 16'h1111);
            @(negedge clk);
            chk("tie_ready", {30'd0, ready1, ready0}, i[0] ? 32'h2 : 32'h1);
            if (i == 4) begin
                chk("tie_cnt0", {24'd0, cnt0}, 32'd2);
                chk("tie_cnt1", {24'd0, cnt1}, 32'd2);
            end
        end

        // Backpressure with 0x1111 held, both requesters valid.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0);
            @(negedge clk);
            chk("bp_ready", {30'd0, ready1, ready0}, 32'd0);
            chk("bp_data", {16'd0, out_data}, 32'h1111);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end

        // Release: same-cycle drain and refill with requester 1.
        step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
        push_exp(1'b1, 16'h2222);
        @(negedge clk);
        chk("refill_ready", {30'd0, ready1, ready0}, 32'h2);
        chk("refill_sel", {31'd0, sel}, 32'd1);
        step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("refill_valid", {31'd0, out_valid}, 32'd1);
        chk("refill_data", {16'd0, out_data}, 32'h2222);
        chk("refill_cnt0", {24'd0, cnt0}, 32'd3);
        chk("refill_cnt1", {24'd0, cnt1}, 32'd3);

        // Reset mid-stream while a word is held.
        do_reset("rst2");

        // Counter wrap: 256 requester 1 words.
        for (int k = 0; k < 256; k++) begin
            step(1'b0, 16'h0000, 1'b1, 16'(k * 3 + 7), 1'b1);
            push_exp(1'b1, 16'(k * 3 + 7));
            if (k == 255) begin
                @(negedge clk);
                chk("wrap_cnt1_ff", {24'd0, cnt1}, 32'hFF);
            end
        end
        step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("wrap_cnt1_zero", {24'd0, cnt1}, 32'h00);
        chk("wrap_cnt0", {24'd0, cnt0}, 32'h00);
        step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("final_empty", {31'd0, out_valid}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
